// File: rtl/adat_rx_bit_slicer.sv
// adat_rx_bit_slicer
//
// Turns one edge-to-edge interval into a run length n, measured in bit
// periods. The bit period comes from the measured frame time. Each run is
// then classified as one of three results:
//   data : 1..MAX_RUN bit periods. The run is emitted as n bits, which are
//          n-1 zeros followed by a 1.
//   sync : SYNC_RUN bit periods. Reported as a one-cycle o_sync pulse.
//   err  : anything else. Reported as a one-cycle o_err pulse.
//
// Fixed-point arithmetic (FRAC fractional bits):
//   P = (frame_time << FRAC) >> FRAME_LOG2
//   E = edge_time << FRAC
// n counts the thresholds (k-0.5)*P, for k = 1.., that E reaches.
// n saturates at SYNC_RUN+1, so P = 0 ends as an error instead of a hang.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_edge                single-cycle pulse; i_edge_time, i_frame_time and
//                         i_sync_mask are valid on this cycle
//   i_sync_mask           1 = emit data runs, 0 = drop data runs
//                         (sync and err are still reported)
//   o_bits, o_bit_count   decoded bits (LSB = latest) and the number of
//                         valid bits in o_bits
//   o_valid, i_ready      output handshake
//   o_sync, o_err         one-cycle pulses
//   o_overrun             one-cycle pulse: an edge was dropped because the
//                         pending register was already full
//
// Handshake: o_valid rises when a data result is loaded into the output
// slot. While o_valid is high, o_bits and o_bit_count hold steady. A
// transfer happens on every cycle where o_valid && i_ready. A new result may
// be loaded on the same cycle that the old one is accepted; o_valid then
// stays high and carries the new data.
module adat_rx_bit_slicer #(
    parameter int TIME_W     = 12,
    parameter int FRAC       = 4,
    parameter int FRAME_LOG2 = 8,
    parameter int MAX_RUN    = 5,
    parameter int SYNC_RUN   = 11
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_edge,
    input  logic [TIME_W-1:0]                i_edge_time,
    input  logic [TIME_W-1:0]                i_frame_time,
    input  logic                             i_sync_mask,
    output logic [MAX_RUN-1:0]               o_bits,
    output logic [$clog2(MAX_RUN+1)-1:0]     o_bit_count,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_sync,
    output logic                             o_err,
    output logic                             o_overrun
);

    localparam int FX_W  = TIME_W + FRAC;
    localparam int N_W   = $clog2(SYNC_RUN + 2);
    // Extra N_W bits stop the accumulator from wrapping.
    // Its largest value is about (SYNC_RUN+1.5)*P.
    localparam int ACC_W = FX_W + N_W;
    localparam int CNT_W = $clog2(MAX_RUN + 1);

    localparam logic [N_W-1:0]     N_LIMIT  = N_W'(SYNC_RUN + 1);
    localparam logic [N_W-1:0]     N_SYNC   = N_W'(SYNC_RUN);
    localparam logic [N_W-1:0]     N_DATA   = N_W'(MAX_RUN);
    localparam logic [MAX_RUN-1:0] BITS_ONE = {{(MAX_RUN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEASURE  = 2'd1,
        CLASSIFY = 2'd2,
        EMIT     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FX_W-1:0]     e_q, e_d;
    logic [FX_W-1:0]     p_q, p_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [N_W-1:0]      n_q, n_d;
    logic                mask_q, mask_d;

    logic                pend_full_q, pend_full_d;
    logic [TIME_W-1:0]   pend_edge_q, pend_edge_d;
    logic [TIME_W-1:0]   pend_frame_q, pend_frame_d;
    logic                pend_mask_q, pend_mask_d;

    logic                valid_q, valid_d;
    logic [MAX_RUN-1:0]  bits_q, bits_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                sync_q, sync_d;
    logic                err_q, err_d;
    logic                ovr_q, ovr_d;

    // Capture source. A waiting pending entry has priority over a live edge.
    logic [TIME_W-1:0]   cap_edge, cap_frame;
    logic                cap_mask;
    logic [FX_W-1:0]     cap_e, cap_p, frame_fx;
    logic                take_pend, edge_direct;
    logic                slot_free, run_more, is_data, is_sync;

    always_comb begin
        cap_edge  = pend_full_q ? pend_edge_q  : i_edge_time;
        cap_frame = pend_full_q ? pend_frame_q : i_frame_time;
        cap_mask  = pend_full_q ? pend_mask_q  : i_sync_mask;
        frame_fx  = {cap_frame, {FRAC{1'b0}}};
        cap_p     = frame_fx >> FRAME_LOG2;
        cap_e     = {cap_edge, {FRAC{1'b0}}};

        take_pend   = (state_q == IDLE) && pend_full_q;
        edge_direct = (state_q == IDLE) && !pend_full_q && i_edge;
        slot_free   = !valid_q || i_ready;
        run_more    = ({{N_W{1'b0}}, e_q} >= acc_q) && (n_q < N_LIMIT);
        is_data     = (n_q != '0) && (n_q <= N_DATA);
        is_sync     = (n_q == N_SYNC);
    end

    always_comb begin
        state_d      = state_q;
        e_d          = e_q;
        p_d          = p_q;
        acc_d        = acc_q;
        n_d          = n_q;
        mask_d       = mask_q;
        pend_full_d  = pend_full_q;
        pend_edge_d  = pend_edge_q;
        pend_frame_d = pend_frame_q;
        pend_mask_d  = pend_mask_q;
        // An accepted result leaves the slot unless it is reloaded below.
        valid_d      = valid_q && !i_ready;
        bits_d       = bits_q;
        count_d      = count_q;
        sync_d       = 1'b0;
        err_d        = 1'b0;
        ovr_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_full_q || i_edge) begin
                    e_d     = cap_e;
                    p_d     = cap_p;
                    acc_d   = ACC_W'(cap_p >> 1);
                    n_d     = '0;
                    mask_d  = cap_mask;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (run_more) begin
                    n_d   = n_q + 1'b1;
                    acc_d = acc_q + ACC_W'(p_q);
                end else begin
                    state_d = CLASSIFY;
                end
            end
            CLASSIFY: begin
                state_d = IDLE;
                if (is_data) begin
                    if (mask_q) begin
                        // Load straight away when the slot can take it.
                        // Otherwise park in EMIT until it can.
                        if (slot_free) begin
                            valid_d = 1'b1;
                            bits_d  = BITS_ONE;
                            count_d = CNT_W'(n_q);
                        end else begin
                            state_d = EMIT;
                        end
                    end
                end else if (is_sync) begin
                    sync_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            EMIT: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    bits_d  = BITS_ONE;
                    count_d = CNT_W'(n_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pending register. An edge that IDLE does not consume directly is
        // parked here. A full entry that IDLE is consuming this cycle frees
        // the register for the new edge.
        if (take_pend) begin
            pend_full_d = 1'b0;
        end
        if (i_edge && !edge_direct) begin
            if (pend_full_q && !take_pend) begin
                ovr_d = 1'b1;
            end else begin
                pend_full_d  = 1'b1;
                pend_edge_d  = i_edge_time;
                pend_frame_d = i_frame_time;
                pend_mask_d  = i_sync_mask;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            e_q          <= '0;
            p_q          <= '0;
            acc_q        <= '0;
            n_q          <= '0;
            mask_q       <= 1'b0;
            pend_full_q  <= 1'b0;
            pend_edge_q  <= '0;
            pend_frame_q <= '0;
            pend_mask_q  <= 1'b0;
            valid_q      <= 1'b0;
            bits_q       <= '0;
            count_q      <= '0;
            sync_q       <= 1'b0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            e_q          <= e_d;
            p_q          <= p_d;
            acc_q        <= acc_d;
            n_q          <= n_d;
            mask_q       <= mask_d;
            pend_full_q  <= pend_full_d;
            pend_edge_q  <= pend_edge_d;
            pend_frame_q <= pend_frame_d;
            pend_mask_q  <= pend_mask_d;
            valid_q      <= valid_d;
            bits_q       <= bits_d;
            count_q      <= count_d;
            sync_q       <= sync_d;
            err_q        <= err_d;
            ovr_q        <= ovr_d;
        end
    end

    assign o_bits      = bits_q;
    assign o_bit_count = count_q;
    assign o_valid     = valid_q;
    assign o_sync      = sync_q;
    assign o_err       = err_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_adat_rx_bit_slicer.sv
// Bench for adat_rx_bit_slicer. Each stimulus edge pushes its predicted
// result: data runs go into one queue, sync/err events into another. A
// negedge monitor pops these queues and compares them with what the block
// presents.
module tb_adat_rx_bit_slicer;

    localparam int TIME_W     = 12;
    localparam int FRAC       = 4;
    localparam int FRAME_LOG2 = 8;
    localparam int MAX_RUN    = 5;
    localparam int SYNC_RUN   = 11;

    localparam logic [1:0] EV_SYNC = 2'd2;
    localparam logic [1:0] EV_ERR  = 2'd3;

    logic              i_clk;
    logic              i_rst;
    logic              i_edge;
    logic [TIME_W-1:0] i_edge_time;
    logic [TIME_W-1:0] i_frame_time;
    logic              i_sync_mask;
    logic [4:0]        o_bits;
    logic [2:0]        o_bit_count;
    logic              o_valid;
    logic              i_ready;
    logic              o_sync;
    logic              o_err;
    logic              o_overrun;

    adat_rx_bit_slicer #(
        .TIME_W(TIME_W), .FRAC(FRAC), .FRAME_LOG2(FRAME_LOG2),
        .MAX_RUN(MAX_RUN), .SYNC_RUN(SYNC_RUN)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_edge(i_edge),
        .i_edge_time(i_edge_time), .i_frame_time(i_frame_time),
        .i_sync_mask(i_sync_mask), .o_bits(o_bits), .o_bit_count(o_bit_count),
        .o_valid(o_valid), .i_ready(i_ready), .o_sync(o_sync), .o_err(o_err),
        .o_overrun(o_overrun)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad   = 0;
    logic [2:0] data_exp_q[$];
    logic [1:0] ev_exp_q[$];
    int         ready_mode = 1;   // 0 = low, 1 = high, 2 = random
    int         exp_ovr = 0;
    int         seen_ovr = 0;
    logic [2:0] exp_cnt;
    logic [1:0] exp_ev;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model. n counts the half-period thresholds
    // (k - 1/2) * P, k = 1..SYNC_RUN+1, that E reaches. The bench keeps
    // P even, so the doubled comparison below is exact.
    function automatic int model_n(input int edge_t, input int frame_t);
        int p, e, n;
        p = (frame_t * (2 ** FRAC)) / (2 ** FRAME_LOG2);
        e = edge_t * (2 ** FRAC);
        n = 0;
        for (int k = 1; k <= SYNC_RUN + 1; k++) begin
            if (2 * e >= (2 * k - 1) * p) n = k;
        end
        return n;
    endfunction

    // Drives a one-cycle edge. Entered and left at posedge + 1.
    task automatic send_edge(input int t, input int f, input bit m, input bit no_expect);
        int n;
        i_edge       = 1'b1;
        i_edge_time  = TIME_W'(t);
        i_frame_time = TIME_W'(f);
        i_sync_mask  = m;
        if (!no_expect) begin
            n = model_n(t, f);
            if (n >= 1 && n <= MAX_RUN) begin
                if (m) data_exp_q.push_back(3'(n));
            end else if (n == SYNC_RUN) begin
                ev_exp_q.push_back(EV_SYNC);
            end else begin
                ev_exp_q.push_back(EV_ERR);
            end
        end
        @(posedge i_clk);
        #1;
        i_edge = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // ---------------- ready driver ----------------
    initial begin
        int rcnt;
        rcnt    = 0;
        i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       i_ready = 1'b0;
                1:       i_ready = 1'b1;
                default: begin
                    // Forced high every fourth cycle so stalls stay short.
                    rcnt++;
                    i_ready = ((rcnt % 4) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                if (data_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_data: count=%0d bits=%b none expected",
                             o_bit_count, o_bits);
                end else begin
                    exp_cnt = data_exp_q.pop_front();
                    check("data_result", int'({o_bits, o_bit_count}), int'({5'b00001, exp_cnt}));
                end
            end
            if (o_sync) begin
                if (ev_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sync: o_sync=1 none expected");
                end else begin
                    exp_ev = ev_exp_q.pop_front();
                    check("sync_event", int'(EV_SYNC), int'(exp_ev));
                end
            end
            if (o_err) begin
                if (ev_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_err: o_err=1 none expected");
                end else begin
                    exp_ev = ev_exp_q.pop_front();
                    check("err_event", int'(EV_ERR), int'(exp_ev));
                end
            end
            if (o_overrun) seen_ovr++;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int fr, p, lim;
        i_rst        = 1'b1;
        i_edge       = 1'b0;
        i_edge_time  = '0;
        i_frame_time = '0;
        i_sync_mask  = 1'b0;
        ready_mode   = 1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs",
              int'({o_bits, o_bit_count, o_valid, o_sync, o_err, o_overrun}), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        wait_cycles(2);

        // Basic data run: n=2, latency n+3.
        send_edge(17, 2048, 1'b1, 1'b0);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            k++;
            if (o_valid) break;
        end
        check("latency_n2", k, 5);
        wait_cycles(25);

        // Sync, with mask on and with mask off.
        send_edge(88, 2048, 1'b1, 1'b0);
        wait_cycles(25);
        send_edge(88, 2048, 1'b0, 1'b0);
        wait_cycles(25);

        // Error runs: n=0 and n=7.
        send_edge(3, 2048, 1'b1, 1'b0);
        wait_cycles(25);
        send_edge(56, 2048, 1'b1, 1'b0);
        wait_cycles(25);

        // Masked data is dropped silently.
        send_edge(17, 2048, 1'b0, 1'b0);
        wait_cycles(25);

        // P = 0 saturates to an error.
        send_edge(5, 10, 1'b1, 1'b0);
        wait_cycles(25);

        // Backpressure: the first edge fills the slot, the second waits in
        // EMIT, the third is held as pending, the fourth overruns.
        ready_mode = 0;
        wait_cycles(2);
        send_edge(8, 2048, 1'b1, 1'b0);
        wait_cycles(8);
        send_edge(8, 2048, 1'b1, 1'b0);
        wait_cycles(8);
        send_edge(8, 2048, 1'b1, 1'b0);
        wait_cycles(2);
        send_edge(8, 2048, 1'b1, 1'b1);
        exp_ovr++;
        @(negedge i_clk);
        check("overrun_pulse", int'(o_overrun), 1);
        check("stall_valid_held", int'(o_valid), 1);
        check("stall_count_held", int'(o_bit_count), 1);
        @(negedge i_clk);
        check("overrun_single", int'(o_overrun), 0);
        @(posedge i_clk);
        #1;
        ready_mode = 1;
        wait_cycles(60);
        check("backpressure_drained", data_exp_q.size(), 0);

        // Reset during MEASURE discards the slot and the measurement.
        ready_mode = 0;
        wait_cycles(2);
        send_edge(8, 2048, 1'b1, 1'b1);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            if (o_valid) break;
            k++;
        end
        check("pre_reset_valid", int'(o_valid), 1);
        @(posedge i_clk);
        #1;
        send_edge(88, 2048, 1'b1, 1'b1);
        wait_cycles(3);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("reset_mid_outputs",
              int'({o_bits, o_bit_count, o_valid, o_sync, o_err, o_overrun}), 0);
        @(posedge i_clk);
        #1;
        ready_mode = 1;
        wait_cycles(3);
        send_edge(17, 2048, 1'b1, 1'b0);
        wait_cycles(25);

        // Randomized edges: mostly single edges, with some back-to-back
        // pairs. The second edge of a pair goes through the pending register.
        ready_mode = 2;
        for (int i = 0; i < 60; i++) begin
            fr  = 32 * $urandom_range(16, 127);
            p   = (fr * 16) / 256;
            lim = (13 * p) / 16 + 2;
            if (lim > 4095) lim = 4095;
            if ($urandom_range(0, 3) == 0) begin
                send_edge($urandom_range(0, lim), fr, 1'($urandom_range(0, 3) != 0), 1'b0);
                send_edge($urandom_range(0, lim), fr, 1'($urandom_range(0, 3) != 0), 1'b0);
                wait_cycles(50);
            end else begin
                send_edge($urandom_range(0, lim), fr, 1'($urandom_range(0, 3) != 0), 1'b0);
                wait_cycles(24);
            end
        end

        // Drain, with a bound.
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            if (data_exp_q.size() == 0 && ev_exp_q.size() == 0) break;
            wait_cycles(1);
        end
        wait_cycles(5);
        check("data_drained", data_exp_q.size(), 0);
        check("events_drained", ev_exp_q.size(), 0);
        check("overrun_count", seen_ovr, exp_ovr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
